// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way set-associative read cache.
// Field positions assume byte addressing with 32-bit words.
package cache_pkg;

   localparam int CACHE_ADDR_W     = 32;
   localparam int CACHE_INDEX_W    = 6;
   localparam int CACHE_LINE_WORDS = 4;

   localparam int CACHE_WORD_LSB = 2;
   localparam int CACHE_OFF_W    = $clog2(CACHE_LINE_WORDS);
   localparam int CACHE_IDX_LSB  = CACHE_WORD_LSB + CACHE_OFF_W;
   localparam int CACHE_TAG_LSB  = CACHE_IDX_LSB + CACHE_INDEX_W;
   localparam int CACHE_TAG_W    = CACHE_ADDR_W - CACHE_TAG_LSB;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOOKUP   = 2'd1,
      ST_MISS_REQ = 2'd2,
      ST_REFILL   = 2'd3
   } cache_state_e;

   // First invalid way wins; otherwise the LRU bit names the victim.
   function automatic logic pick_victim(input logic valid0, input logic valid1, input logic lru);
      if (!valid0)      return 1'b0;
      else if (!valid1) return 1'b1;
      else              return lru;
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid bits, tags and line data, read combinationally by index/word.
// Valid bits clear on reset or flush; tags and data are plain storage.
module cache_way_array
   import cache_pkg::*;
#(
   parameter int INDEX_W    = CACHE_INDEX_W,
   parameter int LINE_WORDS = CACHE_LINE_WORDS,
   parameter int TAG_W      = CACHE_TAG_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic [INDEX_W-1:0]            index_i,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
   input  logic                          wr_data_en_i,
   input  logic [31:0]                   wr_data_i,
   input  logic                          wr_tag_en_i,
   input  logic [TAG_W-1:0]              wr_tag_i,
   output logic                          valid_o,
   output logic [TAG_W-1:0]              tag_o,
   output logic [31:0]                   data_o
);

   localparam int SETS = 1 << INDEX_W;

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS][LINE_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (wr_tag_en_i) begin
         valid_q[index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_tag_en_i) begin
         tag_q[index_i] <= wr_tag_i;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_data_en_i) begin
         data_q[index_i][wr_word_i] <= wr_data_i;
      end
   end

   assign valid_o = valid_q[index_i];
   assign tag_o   = tag_q[index_i];
   assign data_o  = data_q[index_i][rd_word_i];

endmodule

// File: rtl/cache_hit_refill.sv
// Lookup and refill stage of the 2-way read cache: tag compare, LRU, victim choice and line fetch.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_IDLE     | ready for a request or a flush
// ST_LOOKUP   | compare registered address against both ways (first pass or replay)
// ST_MISS_REQ | line fetch request held until memory accepts it
// ST_REFILL   | collecting refill beats into the victim way
module cache_hit_refill
   import cache_pkg::*;
#(
   parameter int ADDR_W     = CACHE_ADDR_W,
   parameter int INDEX_W    = CACHE_INDEX_W,
   parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              flush,
   output logic              rsp_valid,
   output logic              hit0,
   output logic              hit1,
   output logic [31:0]       data_way0,
   output logic [31:0]       data_way1,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_LSB = CACHE_WORD_LSB + OFF_W;
   localparam int TAG_LSB = IDX_LSB + INDEX_W;
   localparam int TAG_W   = ADDR_W - TAG_LSB;
   localparam int SETS    = 1 << INDEX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   cache_state_e                   state_q;
   logic [ADDR_W-1:CACHE_WORD_LSB] addr_q;
   logic [SETS-1:0]                lru_q;
   logic                           victim_q;
   logic                           replay_q;
   logic [OFF_W-1:0]               beat_q;

   logic [OFF_W-1:0]   word;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   assign word  = addr_q[IDX_LSB-1:CACHE_WORD_LSB];
   assign index = addr_q[TAG_LSB-1:IDX_LSB];
   assign tag   = addr_q[ADDR_W-1:TAG_LSB];

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[CACHE_WORD_LSB-1:0];

   logic             in_lookup, in_refill, flush_now, beat_wr, last_beat;
   logic             way_valid [2];
   logic [TAG_W-1:0] way_tag   [2];
   logic [31:0]      way_data  [2];
   logic             way_hit   [2];
   logic             any_hit;

   assign in_lookup = (state_q == ST_LOOKUP);
   assign in_refill = (state_q == ST_REFILL);
   assign flush_now = (state_q == ST_IDLE) && flush;
   assign beat_wr   = in_refill && mem_rsp_valid;
   assign last_beat = beat_wr && (beat_q == LAST_BEAT);

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(
         .INDEX_W    (INDEX_W),
         .LINE_WORDS (LINE_WORDS),
         .TAG_W      (TAG_W)
      ) u_way (
         .clk          (clk),
         .rst          (rst),
         .flush_i      (flush_now),
         .index_i      (index),
         .rd_word_i    (word),
         .wr_word_i    (beat_q),
         .wr_data_en_i (beat_wr && (victim_q == 1'(w))),
         .wr_data_i    (mem_rsp_data),
         .wr_tag_en_i  (last_beat && (victim_q == 1'(w))),
         .wr_tag_i     (tag),
         .valid_o      (way_valid[w]),
         .tag_o        (way_tag[w]),
         .data_o       (way_data[w])
      );
      assign way_hit[w] = in_lookup && way_valid[w] && (way_tag[w] == tag);
   end

   assign any_hit = way_hit[0] || way_hit[1];

   assign req_ready     = !rst && (state_q == ST_IDLE) && !flush;
   assign rsp_valid     = any_hit;
   assign hit0          = way_hit[0];
   assign hit1          = way_hit[1];
   assign data_way0     = in_lookup ? way_data[0] : 32'd0;
   assign data_way1     = in_lookup ? way_data[1] : 32'd0;
   assign mem_req_valid = (state_q == ST_MISS_REQ);
   assign mem_req_addr  = mem_req_valid ? {tag, index, {IDX_LSB{1'b0}}} : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         lru_q    <= '0;
         victim_q <= 1'b0;
         replay_q <= 1'b0;
         beat_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  lru_q <= '0;
               end else if (req_valid) begin
                  addr_q   <= req_addr[ADDR_W-1:CACHE_WORD_LSB];
                  replay_q <= 1'b0;
                  state_q  <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (any_hit) begin
                  // lru points at the way that was not just used
                  lru_q[index] <= way_hit[0];
                  state_q      <= ST_IDLE;
               end else begin
                  victim_q <= pick_victim(way_valid[0], way_valid[1], lru_q[index]);
                  state_q  <= ST_MISS_REQ;
               end
            end
            ST_MISS_REQ: begin
               if (mem_req_ready) begin
                  beat_q  <= '0;
                  state_q <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (mem_rsp_valid) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     replay_q <= 1'b1;
                     state_q  <= ST_LOOKUP;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (in_lookup) begin
         if (any_hit && !replay_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (!any_hit)             miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_hit_refill.sv
// Directed plus randomized bench for cache_hit_refill against an array-based cache model.
// Counter outputs are checked when CACHE_PERF_CNT_EN is defined.
module tb_cache_hit_refill;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        flush;
   logic        rsp_valid;
   logic        hit0, hit1;
   logic [31:0] data_way0, data_way1;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   cache_hit_refill dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .flush         (flush),
      .rsp_valid     (rsp_valid),
      .hit0          (hit0),
      .hit1          (hit1),
      .data_way0     (data_way0),
      .data_way1     (data_way1),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
`ifdef CACHE_PERF_CNT_EN
      ,
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: per-way valid/tag/line arrays, one LRU bit per set, event counts.
   bit          m_vld [2][64];
   logic [31:0] m_tag [2][64];
   logic [31:0] m_dat [2][64][4];
   bit          m_lru [64];
   int          m_hits, m_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 64; s++) m_vld[w][s] = 1'b0;
      for (int s = 0; s < 64; s++) m_lru[s] = 1'b0;
   endtask

   task automatic chk_counters();
`ifdef CACHE_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_miss);
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (req_ready !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic chk_idle_zero(input string pfx);
      chk({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({pfx, "_hits"}, {30'd0, hit1, hit0}, 32'd0);
      chk({pfx, "_data_way0"}, data_way0, 32'd0);
      chk({pfx, "_data_way1"}, data_way1, 32'd0);
      chk({pfx, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      chk({pfx, "_mem_req_addr"}, mem_req_addr, 32'd0);
   endtask

   task automatic do_flush(input logic [31:0] addr);
      wait_ready();
      flush = 1'b1;
      req_valid = 1'b1;
      req_addr = addr;
      #1;
      chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
      step();
      flush = 1'b0;
      req_valid = 1'b0;
      #1;
      model_clear();
      chk("flush_not_accepted", {31'd0, req_ready}, 32'd1);
      chk_idle_zero("flush");
   endtask

   // One request end to end; rst_after >= 0 aborts the refill with a reset after that many beats.
   task automatic access(input logic [31:0] addr, input int rdy_dly, input logic [31:0] beat0,
                         input int rst_after, input bit extra_beat);
      int          idx, wd, way, vic;
      logic [31:0] t;
      bit          hit;
      int          n;
      idx = int'((addr >> 4) & 32'h3F);
      wd  = int'((addr >> 2) & 32'h3);
      t   = addr >> 10;
      hit = 1'b0;
      way = 0;
      for (int w = 0; w < 2; w++)
         if (m_vld[w][idx] && m_tag[w][idx] == t) begin
            hit = 1'b1;
            way = w;
         end

      wait_ready();
      req_valid = 1'b1;
      req_addr = addr;
      step();
      req_valid = 1'b0;
      req_addr = $urandom;
      #1;
      chk("lookup_rsp_valid", {31'd0, rsp_valid}, {31'd0, hit});
      chk("lookup_hit0", {31'd0, hit0}, {31'd0, hit && way == 0});
      chk("lookup_hit1", {31'd0, hit1}, {31'd0, hit && way == 1});
      chk("lookup_req_ready", {31'd0, req_ready}, 32'd0);
      chk("lookup_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      for (int w = 0; w < 2; w++)
         if (m_vld[w][idx]) chk("lookup_data", (w == 0) ? data_way0 : data_way1, m_dat[w][idx][wd]);

      if (hit) begin
         m_lru[idx] = (way == 0);
         m_hits++;
         step();
         chk("hit_back_idle", {31'd0, req_ready}, 32'd1);
         chk_counters();
         return;
      end

      m_miss++;
      vic = !m_vld[0][idx] ? 0 : (!m_vld[1][idx] ? 1 : int'(m_lru[idx]));
      step();
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("mem_req_addr", mem_req_addr, addr & 32'hFFFF_FFF0);
      chk_counters();
      for (int k = 0; k < rdy_dly; k++) begin
         step();
         chk("hold_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
         chk("hold_mem_req_addr", mem_req_addr, addr & 32'hFFFF_FFF0);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      #1;
      chk("single_fetch", {31'd0, mem_req_valid}, 32'd0);
      chk("refill_addr_zero", mem_req_addr, 32'd0);

      for (int b = 0; b < 4; b++) begin
         if (rst_after == b) begin
            rst = 1'b1;
            #1;
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            step();
            rst = 1'b0;
            #1;
            model_clear();
            m_hits = 0;
            m_miss = 0;
            chk_idle_zero("post_rst");
            chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk_counters();
            mem_rsp_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
               mem_rsp_data = $urandom;
               step();
               chk_idle_zero("stray_beat");
            end
            mem_rsp_valid = 1'b0;
            return;
         end
         n = int'($urandom_range(0, 2));
         for (int g = 0; g < n; g++) step();
         mem_rsp_valid = 1'b1;
         mem_rsp_data = beat0 + 32'(b);
         step();
         if (!(extra_beat && b == 3)) mem_rsp_valid = 1'b0;
         else mem_rsp_data = ~beat0;
      end
      #1;
      for (int b = 0; b < 4; b++) m_dat[vic][idx][b] = beat0 + 32'(b);
      m_vld[vic][idx] = 1'b1;
      m_tag[vic][idx] = t;
      m_lru[idx] = (vic == 0);
      chk("replay_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("replay_hit0", {31'd0, hit0}, {31'd0, vic == 0});
      chk("replay_hit1", {31'd0, hit1}, {31'd0, vic == 1});
      chk("replay_data", (vic == 0) ? data_way0 : data_way1, beat0 + 32'(wd));
      chk("replay_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      step();
      mem_rsp_valid = 1'b0;
      chk("replay_back_idle", {31'd0, req_ready}, 32'd1);
      chk_counters();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] tags [4];
      logic [31:0] a;
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      flush = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      model_clear();
      m_hits = 0;
      m_miss = 0;
      tags[0] = 32'h0;
      tags[1] = 32'h1;
      tags[2] = 32'h2;
      tags[3] = 32'h3F_FFFF;

      step();
      step();
      chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
      chk_idle_zero("reset");
      rst = 1'b0;
      #1;
      chk("first_idle_req_ready", {31'd0, req_ready}, 32'd1);
      chk_counters();

      access(32'h0000_0104, 0, 32'h0000_00A0, -1, 1'b0);
      access(32'h0000_010C, 0, 32'h0, -1, 1'b0);
      access(32'h0000_0504, 0, $urandom, -1, 1'b0);
      access(32'h0000_0904, 5, $urandom, -1, 1'b1);
      access(32'h0000_0104, 1, $urandom, -1, 1'b0);
      access(32'h0000_0908, 0, 32'h0, -1, 1'b0);

      do_flush(32'h0000_0104);
      access(32'h0000_0104, 0, $urandom, -1, 1'b0);

      access(32'h0000_0204, 0, $urandom, 2, 1'b0);
      access(32'h0000_0204, 0, $urandom, -1, 1'b0);
      access(32'h0000_0104, 0, $urandom, -1, 1'b0);

      for (int i = 0; i < 80; i++) begin
         a = (tags[$urandom_range(0, 3)] << 10)
           | (32'($urandom_range(0, 3) * 21) << 4)
           | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) do_flush(a);
         else access(a, int'($urandom_range(0, 3)), $urandom, -1, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
